// File: rtl/svm_pkg.sv
// Shared constants for the three-phase switching sequencer: phase gate codes,
// parameter defaults and the duty word width.
package svm_pkg;
  localparam int DUTY_W            = 16;
  localparam int PERIOD_DEFAULT    = 20;
  localparam int MIN_DWELL_DEFAULT = 4;

  typedef enum logic [5:0] {
    PH_A = 6'b000011,
    PH_B = 6'b001100,
    PH_C = 6'b110000
  } phase_e;
endpackage

// File: rtl/svm_duty_shadow.sv
// Single-entry shadow for a duty pair with valid/ready handshake; the pair is
// clipped to the period and moved into the active set at the period wrap.
module svm_duty_shadow
  import svm_pkg::*;
#(
  parameter int PERIOD = PERIOD_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d_valid,
  output logic              d_ready,
  input  logic [DUTY_W-1:0] d_a,
  input  logic [DUTY_W-1:0] d_b,
  input  logic              wrap,
  output logic [DUTY_W-1:0] a_act,
  output logic [DUTY_W-1:0] b_act
);
  localparam logic [DUTY_W-1:0] P = DUTY_W'(PERIOD);

  logic              full;
  logic [DUTY_W-1:0] sa, sb;
  logic [DUTY_W-1:0] a_clip, b_clip, rem;

  assign d_ready = ~full;

  always_comb begin
    a_clip = (sa > P) ? P : sa;
    rem    = P - a_clip;
    b_clip = (sb > rem) ? rem : sb;
  end

  // Accept is only possible while empty, so it never collides with a load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full  <= 1'b0;
      sa    <= '0;
      sb    <= '0;
      a_act <= P;
      b_act <= '0;
    end else if (d_valid && !full) begin
      sa   <= d_a;
      sb   <= d_b;
      full <= 1'b1;
    end else if (wrap && full) begin
      a_act <= a_clip;
      b_act <= b_clip;
      full  <= 1'b0;
    end
  end
endmodule

// File: rtl/phase_sequencer.sv
// Centre-aligned A/B/C/B/A phase sequencer with a minimum dwell on the gate
// pattern and a current-direction register frozen across each commutation.
module phase_sequencer
  import svm_pkg::*;
#(
  parameter int PERIOD    = PERIOD_DEFAULT,
  parameter int MIN_DWELL = MIN_DWELL_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d_valid,
  output logic              d_ready,
  input  logic [DUTY_W-1:0] d_a,
  input  logic [DUTY_W-1:0] d_b,
  input  logic              i_sign,
  output logic [5:0]        vnew,
  output logic              dir,
  output logic              pstart
);
  localparam logic [DUTY_W-1:0] P  = DUTY_W'(PERIOD);
  localparam int                HW = $clog2(MIN_DWELL + 1);
  localparam logic [HW-1:0]     DW_MAX = HW'(MIN_DWELL);

  logic [DUTY_W-1:0] cnt, a_act, b_act;
  logic [DUTY_W-1:0] c_len, e1, e2, e3, e4;
  logic              wrap, change;
  logic [HW-1:0]     hold;
  phase_e            ph, target;

  assign wrap = (cnt == P - DUTY_W'(1));
  assign vnew = ph;

  svm_duty_shadow #(.PERIOD(PERIOD)) u_shadow (
    .clk     (clk),
    .rst     (rst),
    .d_valid (d_valid),
    .d_ready (d_ready),
    .d_a     (d_a),
    .d_b     (d_b),
    .wrap    (wrap),
    .a_act   (a_act),
    .b_act   (b_act)
  );

  // B is split around C; the odd cycle of B goes to the trailing half.
  always_comb begin
    c_len = P - a_act - b_act;
    e1    = a_act >> 1;
    e2    = e1 + (b_act >> 1);
    e3    = e2 + c_len;
    e4    = e3 + (b_act - (b_act >> 1));
    target = PH_A;
    if      (cnt < e1) target = PH_A;
    else if (cnt < e2) target = PH_B;
    else if (cnt < e3) target = PH_C;
    else if (cnt < e4) target = PH_B;
  end

  // hold counts cycles the current pattern has been shown, saturating.
  assign change = (target != ph) && (hold == DW_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      ph     <= PH_A;
      hold   <= DW_MAX;
      dir    <= 1'b0;
      pstart <= 1'b0;
    end else begin
      cnt    <= wrap ? '0 : cnt + DUTY_W'(1);
      pstart <= wrap;
      if (change) begin
        ph   <= target;
        hold <= HW'(1);
      end else if (hold != DW_MAX) begin
        hold <= hold + HW'(1);
      end
      if (!change && hold == DW_MAX)
        dir <= i_sign;
    end
  end
endmodule
